// File: rtl/mac_framer_pkg.sv
// Shared widths, FSM state type and output FIFO entry layout for the MAC dot-product framer.
package mac_framer_pkg;

    localparam int OP_W  = 8;
    localparam int ACC_W = 17;

    typedef enum logic [1:0] {
        CLEAR   = 2'd0,
        ACCUM   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    typedef struct packed {
        logic             ovf;
        logic [ACC_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/framer_fifo.sv
// Synchronous FIFO with a combinational head view (zero when empty); simultaneous
// push and pop are both honoured, even when full.
module framer_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic [7:0]
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int AW = $clog2(DEPTH);

    entry_t           mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/mac_dot_framer.sv
// Frames a free-running MAC into VEC_LEN-pair dot products queued in an output FIFO.
// Optional wrap detection is built when MAC_FRAMER_OVF_DET_EN is defined.
module mac_dot_framer
    import mac_framer_pkg::*;
#(
    parameter int VEC_LEN    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  din_a,
    input  logic [OP_W-1:0]  din_b,
    output logic [OP_W-1:0]  mac_a,
    output logic [OP_W-1:0]  mac_b,
    output logic             mac_clr,
    input  logic [ACC_W-1:0] mac_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf
);

    localparam int CNT_W = $clog2(VEC_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

    state_t             state_reg;
    state_t             state_next;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;
    logic               accept;
    logic               push;
    logic               fifo_full;
    logic               fifo_empty;
    logic               frame_ovf;
    fifo_entry_t        push_entry;
    fifo_entry_t        head_entry;

    assign in_ready = (state_reg == ACCUM);
    assign accept   = in_ready && in_valid;
    // fifo_full is registered, so mac_clr never depends combinationally on out_ready.
    assign push     = (state_reg == CAPTURE) && !fifo_full;
    assign mac_clr  = (state_reg == CLEAR) || push;
    assign mac_a    = accept ? din_a : '0;
    assign mac_b    = accept ? din_b : '0;

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            CLEAR: begin
                state_next = ACCUM;
                count_next = '0;
            end
            ACCUM: begin
                if (accept) begin
                    if (count_reg == LAST_IDX) begin
                        state_next = CAPTURE;
                        count_next = '0;
                    end else begin
                        count_next = count_reg + CNT_W'(1);
                    end
                end
            end
            CAPTURE: begin
                if (push) begin
                    state_next = ACCUM;
                    count_next = '0;
                end
            end
            default: begin
                state_next = CLEAR;
                count_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= CLEAR;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

`ifdef MAC_FRAMER_OVF_DET_EN
    logic [ACC_W-1:0] acc_prev_reg;
    logic             ovf_sticky_reg;
    logic             wrapped;

    // Products are nonnegative and below 2^17, so any decrease means a wrap.
    assign wrapped = (mac_acc < acc_prev_reg);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_prev_reg   <= '0;
            ovf_sticky_reg <= 1'b0;
        end else begin
            case (state_reg)
                ACCUM: begin
                    acc_prev_reg <= mac_acc;
                    if (wrapped) begin
                        ovf_sticky_reg <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (push) begin
                        acc_prev_reg   <= '0;
                        ovf_sticky_reg <= 1'b0;
                    end
                end
                default: begin
                    acc_prev_reg   <= '0;
                    ovf_sticky_reg <= 1'b0;
                end
            endcase
        end
    end

    // The last product only becomes visible in CAPTURE, so its wrap is folded in here.
    assign frame_ovf = ovf_sticky_reg || ((state_reg == CAPTURE) && wrapped);
`else
    assign frame_ovf = 1'b0;
`endif

    assign push_entry.ovf  = frame_ovf;
    assign push_entry.data = mac_acc;

    framer_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (fifo_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (out_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head_entry)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = head_entry.data;
    assign out_ovf   = head_entry.ovf;

endmodule

// File: doc/mac_dot_framer.md
# mac_dot_framer

- Sits between the operand source and `multiply_and_accumulate`; turns its free-running accumulator into framed dot products.
- Accepts operand pairs over a valid/ready handshake and forwards them to the MAC.
- After every VEC_LEN accepted pairs, captures the MAC accumulator into an output FIFO and clears the MAC for the next frame.
- Results leave over a valid/ready handshake, each with an optional wrap-around flag.

## Interface
- VEC_LEN, 4: operand pairs per frame (≥1).
- FIFO_DEPTH, 4: output FIFO entries (power of 2, ≥2).
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand pair present.
- in_ready  output  1  framer accepts the pair this cycle.
- din_a  input  8  operand A, unsigned.
- din_b  input  8  operand B, unsigned.
- mac_a  output  8  to MAC `a`.
- mac_b  output  8  to MAC `b`.
- mac_clr  output  1  to MAC `rst`; high clears the accumulator at the next edge.
- mac_acc  input  17  from MAC `acc`.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer takes the head entry.
- out_data  output  17  frame dot product (FIFO head).
- out_ovf  output  1  frame accumulator wrapped (FIFO head).

## Operation
States: CLEAR, ACCUM, CAPTURE. Reset state is CLEAR.

- **CLEAR**
  - mac_clr=1, in_ready=0.
  - Next cycle → ACCUM with pair count 0.
- **ACCUM**
  - in_ready=1.
  - On accept: mac_a=din_a, mac_b=din_b, count+1. Otherwise mac_a=mac_b=0, so the accumulator holds.
  - Accepting pair VEC_LEN → CAPTURE.
- **CAPTURE**
  - in_ready=0, mac_a=mac_b=0. mac_acc now includes the last product.
  - FIFO not full: push {mac_acc, ovf_sticky}, mac_clr=1, clear ovf_sticky, count=0, → ACCUM.
  - FIFO full: stay in CAPTURE with mac_clr=0, accumulator held, until space exists.
- **mac_clr**
  - mac_clr = (state==CLEAR) | (state==CAPTURE & !fifo_full).
  - Combinational from registered state; no glitch paths from inputs.
- **Arithmetic**
  - The MAC is 17-bit and wraps modulo 2^17; the framer does no arithmetic on data.
  - out_data is exactly mac_acc at capture.
- **Output FIFO**
  - Push and pop in the same cycle are both performed, including when full: the pop frees space, so the push succeeds.
  - out_data and out_ovf show the head entry; both are 0 when empty.
- **Reset** (any time, including mid-frame)
  - State CLEAR, count 0, FIFO empty, ovf_sticky 0.
  - Partial frame discarded.

## Timing
- Reset values: in_ready 0, mac_a 0, mac_b 0, mac_clr 1, out_valid 0, out_data 0, out_ovf 0.
- First accept possible 1 cycle after rst deasserts.
- Frame latency: last pair accepted at edge t; captured at edge t+1; out_valid high after edge t+1.
- Frame gap: one CAPTURE cycle with in_ready=0. Throughput is VEC_LEN pairs per VEC_LEN+1 cycles.
- Pop: out_valid & out_ready at an edge removes the head entry.

## Configuration
- MAC_FRAMER_OVF_DET_EN defined:
  - In ACCUM, register mac_acc each cycle. The first ACCUM cycle after CLEAR/CAPTURE starts from 0.
  - If mac_acc < the previous value, set ovf_sticky. Products are nonnegative and < 2^17, so a decrease means the accumulator wrapped.
- MAC_FRAMER_OVF_DET_EN undefined:
  - No shadow register; ovf_sticky and out_ovf are constant 0.
  - The port remains.

## Structure
- Package mac_framer_pkg holds:
  - OP_W=8 and ACC_W=17;
  - the state enum {CLEAR, ACCUM, CAPTURE};
  - the FIFO entry struct {ovf, data}.
- Sub-module framer_fifo:
  - synchronous FIFO parameterised on depth and entry type;
  - ports push/pop/full/empty/head;
  - same clk and rst.
- FSM, pair counter and overflow shadow live in the top.

## Test plan
- Reset: hold rst=0 → in_ready=0, mac_clr=1, out_valid=0. Release → CLEAR for one cycle, then in_ready=1.
- Basic frame: VEC_LEN=4, pairs (0x04,0x03), (0x02,0x06), (0x10,0x02), (0x04,0x06) on consecutive cycles → out_data=0x00050 (80), out_ovf=0. out_valid rises 2 edges after the 4th accept; mac_clr=1 in the CAPTURE cycle.
- Idle gaps: same pairs with in_valid low between them → mac_a=mac_b=0 in gap cycles, result still 0x00050.
- Overflow: pairs (0xFF,0xFF)×3 then (0,0) → out_data=0x0FA03 (195075 mod 2^17). out_ovf=1 with the macro, 0 without. The next frame of the basic pairs gives out_ovf=0.
- Backpressure:
  - out_ready=0 and 5 frames offered → 4 entries buffered; framer stalls in CAPTURE with in_ready=0 and mac_clr=0.
  - out_ready=1 → fifth result pushed the cycle after the first pop, in order.
- Reset mid-frame: rst=0 after 2 accepted pairs → FIFO empty, count 0. The next full frame equals only its own 4 pairs.
